// File: rtl/tile_sort_sequencer.sv
// Frame-paced bubble-sort controller: one compare/exchange step every FRAMES_PER_STEP
// frame ticks, so the sort animates on screen. All outputs come straight from registers.
module tile_sort_sequencer #(
  parameter int unsigned N_TILES         = 5,
  parameter int unsigned VAL_W           = 4,
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         load,
  input  logic [N_TILES*VAL_W-1:0]     load_data,
  input  logic                         start,
  output logic [N_TILES*VAL_W-1:0]     tile_vals,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_TILES)-1:0]   cmp_idx,
  output logic                         cmp_valid,
  output logic                         swapped,
  output logic [7:0]                   swap_count
);

  localparam int unsigned IdxW = $clog2(N_TILES);
  localparam int unsigned FcW  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [FcW-1:0]  FcLast   = FcW'(FRAMES_PER_STEP - 1);
  localparam logic [IdxW-1:0] LastPass = IdxW'(N_TILES - 2);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StWait    = 3'd1;
  localparam logic [2:0] StCompare = 3'd2;
  localparam logic [2:0] StSwap    = 3'd3;
  localparam logic [2:0] StNext    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [VAL_W-1:0] vals_q [N_TILES];
  logic [VAL_W-1:0] vals_d [N_TILES];
  logic [VAL_W-1:0] load_vals [N_TILES];
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  pass_q, pass_d;
  logic [FcW-1:0]   fcnt_q, fcnt_d;
  logic             swap_flag_q, swap_flag_d;
  logic [7:0]       swap_cnt_q, swap_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             swapped_q, swapped_d;

  logic [IdxW-1:0]  idx_nxt;
  logic [VAL_W-1:0] left_val, right_val;
  logic             more_in_pass;

  for (genvar k = 0; k < N_TILES; k++) begin : g_pack
    assign tile_vals[k*VAL_W +: VAL_W] = vals_q[k];
    assign load_vals[k]                = load_data[k*VAL_W +: VAL_W];
  end

  // idx_q never exceeds N_TILES-2, so idx_nxt always addresses a real tile.
  assign idx_nxt      = idx_q + IdxW'(1);
  assign left_val     = vals_q[idx_q];
  assign right_val    = vals_q[idx_nxt];
  assign more_in_pass = (int'(idx_q) + int'(pass_q)) < (int'(N_TILES) - 2);

  always_comb begin
    state_d     = state_q;
    vals_d      = vals_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    fcnt_d      = fcnt_q;
    swap_flag_d = swap_flag_q;
    swap_cnt_d  = swap_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    swapped_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (load) begin
          vals_d = load_vals;
          done_d = 1'b0;
        end else if (start) begin
          state_d     = StWait;
          idx_d       = '0;
          pass_d      = '0;
          swap_flag_d = 1'b0;
          fcnt_d      = '0;
          swap_cnt_d  = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end

      StWait: begin
        if (frame_tick) begin
          if (fcnt_q == FcLast) begin
            fcnt_d  = '0;
            state_d = StCompare;
          end else begin
            fcnt_d = fcnt_q + FcW'(1);
          end
        end
      end

      StCompare: begin
        // Strict compare keeps equal tiles in order.
        if (left_val > right_val) begin
          state_d   = StSwap;
          swapped_d = 1'b1;
        end else begin
          state_d = StNext;
        end
      end

      StSwap: begin
        vals_d[idx_q]   = right_val;
        vals_d[idx_nxt] = left_val;
        swap_flag_d     = 1'b1;
        if (swap_cnt_q != 8'hFF) begin
          swap_cnt_d = swap_cnt_q + 8'd1;
        end
        state_d = StNext;
      end

      StNext: begin
        if (more_in_pass) begin
          idx_d   = idx_nxt;
          state_d = StWait;
        end else if (!swap_flag_q || (pass_q == LastPass)) begin
          idx_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          pass_d      = pass_q + IdxW'(1);
          idx_d       = '0;
          swap_flag_d = 1'b0;
          state_d     = StWait;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      vals_q      <= '{default: '0};
      idx_q       <= '0;
      pass_q      <= '0;
      fcnt_q      <= '0;
      swap_flag_q <= 1'b0;
      swap_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      swapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vals_q      <= vals_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fcnt_q      <= fcnt_d;
      swap_flag_q <= swap_flag_d;
      swap_cnt_q  <= swap_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      swapped_q   <= swapped_d;
    end
  end

  assign busy       = busy_q;
  assign cmp_valid  = busy_q;
  assign done       = done_q;
  assign cmp_idx    = idx_q;
  assign swapped    = swapped_q;
  assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_tile_sort_sequencer.sv
// Scoreboarded bench for tile_sort_sequencer: a reference bubble sort queues the expected
// compare and exchange indices, which are popped as the DUT steps through the sort.
module tb_tile_sort_sequencer;

  localparam int N   = 5;
  localparam int W   = 4;
  localparam int FPS = 2;
  localparam int IW  = $clog2(N);

  logic           clk = 1'b0;
  logic           reset, frame_tick, load, start;
  logic [N*W-1:0] load_data, tile_vals;
  logic           busy, done, cmp_valid, swapped;
  logic [IW-1:0]  cmp_idx;
  logic [7:0]     swap_count;

  int checks = 0;
  int failures = 0;
  int ticks;
  int cmp_q[$];
  int swp_q[$];
  logic [N*W-1:0] exp_vals;
  int exp_swaps, exp_cmps;

  always #5 clk = ~clk;

  tile_sort_sequencer #(
    .N_TILES        (N),
    .VAL_W          (W),
    .FRAMES_PER_STEP(FPS)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .load      (load),
    .load_data (load_data),
    .start     (start),
    .tile_vals (tile_vals),
    .busy      (busy),
    .done      (done),
    .cmp_idx   (cmp_idx),
    .cmp_valid (cmp_valid),
    .swapped   (swapped),
    .swap_count(swap_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int a0, a1, a2, a3, a4);
    return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Reference bubble sort with early exit; fills the scoreboard queues.
  function automatic void model(input logic [N*W-1:0] d);
    logic [W-1:0] v [N];
    logic [W-1:0] t;
    bit flag;
    for (int k = 0; k < N; k++) v[k] = d[k*W +: W];
    exp_swaps = 0;
    exp_cmps  = 0;
    for (int p = 0; p <= N - 2; p++) begin
      flag = 1'b0;
      for (int i = 0; i <= N - 2 - p; i++) begin
        cmp_q.push_back(i);
        exp_cmps++;
        if (v[i] > v[i+1]) begin
          t = v[i]; v[i] = v[i+1]; v[i+1] = t;
          swp_q.push_back(i);
          exp_swaps++;
          flag = 1'b1;
        end
      end
      if (!flag) break;
    end
    for (int k = 0; k < N; k++) exp_vals[k*W +: W] = v[k];
  endfunction

  // Every exchange pulse must match the next expected exchange index.
  always @(negedge clk) begin
    int e;
    if (swapped) begin
      if (swp_q.size() > 0) e = swp_q.pop_front();
      else e = 7;
      check_eq("swap_idx", 64'(cmp_idx), 64'(e));
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_tiles"}, 64'(tile_vals), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_cmp_idx"}, 64'(cmp_idx), 64'(0));
    check_eq({tag, "_cmp_valid"}, 64'(cmp_valid), 64'(0));
    check_eq({tag, "_swapped"}, 64'(swapped), 64'(0));
    check_eq({tag, "_swap_count"}, 64'(swap_count), 64'(0));
  endtask

  task automatic begin_sort(input string tag, input logic [N*W-1:0] d);
    model(d);
    @(negedge clk); load = 1'b1; load_data = d;
    @(negedge clk); load = 1'b0; start = 1'b1;
    check_eq({tag, "_load_tiles"}, 64'(tile_vals), 64'(d));
    check_eq({tag, "_load_done"}, 64'(done), 64'(0));
    @(negedge clk); start = 1'b0;
    check_eq({tag, "_busy_on"}, 64'(busy), 64'(1));
    check_eq({tag, "_valid_on"}, 64'(cmp_valid), 64'(1));
    ticks = 0;
  endtask

  task automatic tick_step(input string tag);
    int e;
    @(negedge clk); frame_tick = 1'b1; ticks++;
    if (ticks % FPS == 0) begin
      if (cmp_q.size() > 0) e = cmp_q.pop_front();
      else e = 7;
      check_eq({tag, "_cmp_idx"}, 64'(cmp_idx), 64'(e));
    end
    @(negedge clk); frame_tick = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic finish_sort(input string tag, input int inject_at);
    while (busy && ticks < 400) begin
      tick_step(tag);
      if (ticks == inject_at) begin
        @(negedge clk); load = 1'b1; start = 1'b1; load_data = ~load_data;
        @(negedge clk); load = 1'b0; start = 1'b0;
      end
    end
    check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
    check_eq({tag, "_done_end"}, 64'(done), 64'(1));
    check_eq({tag, "_tiles_end"}, 64'(tile_vals), 64'(exp_vals));
    check_eq({tag, "_swap_count"}, 64'(swap_count), 64'(exp_swaps));
    check_eq({tag, "_ticks"}, 64'(ticks), 64'(exp_cmps * FPS));
    check_eq({tag, "_cmp_left"}, 64'(cmp_q.size()), 64'(0));
    check_eq({tag, "_swp_left"}, 64'(swp_q.size()), 64'(0));
  endtask

  initial begin
    logic [N*W-1:0] r;
    // Reset must win over a simultaneous load/start.
    reset = 1'b1; load = 1'b1; start = 1'b1; frame_tick = 1'b0; load_data = '1;
    repeat (2) @(negedge clk);
    reset = 1'b0; load = 1'b0; start = 1'b0;
    check_reset("rst0");

    begin_sort("rev", pack(4, 3, 2, 1, 0));
    finish_sort("rev", -1);
    check_eq("rev_sorted", 64'(tile_vals), 64'(pack(0, 1, 2, 3, 4)));
    check_eq("rev_swaps10", 64'(swap_count), 64'(10));

    begin_sort("fwd", pack(0, 1, 2, 3, 4));
    finish_sort("fwd", -1);

    begin_sort("dup", pack(2, 2, 1, 1, 3));
    finish_sort("dup", -1);
    check_eq("dup_swaps4", 64'(swap_count), 64'(4));

    // Load+start while busy must be ignored.
    begin_sort("inj", pack(4, 3, 2, 1, 0));
    finish_sort("inj", 5);

    // Idle load+start: load wins, no sort starts.
    @(negedge clk); load_data = pack(9, 8, 7, 6, 5); load = 1'b1; start = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b0;
    check_eq("ls_tiles", 64'(tile_vals), 64'(pack(9, 8, 7, 6, 5)));
    check_eq("ls_busy", 64'(busy), 64'(0));
    check_eq("ls_done", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check_eq("ls_busy_hold", 64'(busy), 64'(0));

    // Reset 7 frame ticks into a sort.
    begin_sort("mid", pack(4, 3, 2, 1, 0));
    repeat (7) tick_step("mid");
    @(negedge clk); reset = 1'b1; load = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; load = 1'b0; start = 1'b0;
    check_reset("rst_mid");
    cmp_q.delete();
    swp_q.delete();

    begin_sort("post", pack(3, 0, 4, 1, 2));
    finish_sort("post", -1);

    for (int n = 0; n < 2; n++) begin
      r = (N*W)'($urandom);
      begin_sort("rnd", r);
      finish_sort("rnd", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
